// File: rtl/sici_pcs_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sici_pcs_tx_pkg                                                      |
// | Shared Sici PCS definitions: sync headers, frame patterns, states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sici_pcs_tx_pkg;

  localparam logic [1:0] SH_DAT = 2'b01;
  localparam logic [1:0] SH_CTL = 2'b10;

  // Patterns are held wide and sliced to the payload width by each user.
  localparam int PAT_MAX_W = 256;
  localparam logic [PAT_MAX_W-1:0] IDLE_PAT_W = '0;
  localparam logic [PAT_MAX_W-1:0] TRN_PAT_W  = {128{2'b10}};
  localparam logic [PAT_MAX_W-1:0] AM_PAT_W   = '1;

  typedef enum logic [0:0] {
    ST_TRAIN = 1'b0,
    ST_RUN   = 1'b1
  } pcs_state_t;

  function automatic int bit_size(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sici_pcs_scr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sici_pcs_scr                                                         |
// | Parallel self-synchronous scrambler x^58+x^39+1, LSB processed first;|
// | built only when SICI_PCS_TX_SCR_EN is defined.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sici_pcs_scr
  import sici_pcs_tx_pkg::*;
#(
  parameter int W = 94
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [57:0] r_state;
  logic [57:0] w_state_nxt;

  always_comb begin
    logic [57:0] s;
    s    = r_state;
    dout = '0;
    for (int i = 0; i < W; i++) begin
      dout[i] = din[i] ^ s[57] ^ s[38];
      s       = {s[56:0], dout[i]};
    end
    w_state_nxt = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_state <= 58'h3FF_FFFF_FFFF_FFFF;
    else if (en) r_state <= w_state_nxt;
  end

endmodule
`default_nettype wire

// File: rtl/sici_pcs_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sici_pcs_tx                                                          |
// | Sici PCS frame transmitter: training burst, user/idle frames and     |
// | periodic align markers. Define SICI_PCS_TX_SCR_EN to scramble data.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sici_pcs_tx
  import sici_pcs_tx_pkg::*;
#(
  parameter int FW  = 96,
  parameter int TRN = 64,
  parameter int AMP = 4096
) (
  input  logic          Ck,
  input  logic          Rs,
  input  logic          CE,
  input  logic [FW-3:0] Usr_Dat,
  input  logic          Usr_Ctl,
  input  logic          Usr_Vld,
  output logic          Usr_Rdy,
  input  logic          Re_Trn,
  output logic [FW-1:0] Phy_Dat,
  output logic          Trn_Act,
  output logic          AM_Pls
);

  localparam int PW  = FW - 2;
  localparam int FCW = (AMP > 1) ? $clog2(AMP) : 1;
  localparam int TCW = bit_size(TRN);
  localparam logic [PW-1:0] IDLE_PAT = IDLE_PAT_W[PW-1:0];
  localparam logic [PW-1:0] TRN_PAT  = TRN_PAT_W[PW-1:0];
  localparam logic [PW-1:0] AM_PAT   = AM_PAT_W[PW-1:0];

  logic [1:0]     r_rs_sync;
  logic           w_rst_n;
  logic [2:0]     r_rt_sync;
  logic           w_rt_pe;
  pcs_state_t     r_state, w_state_nxt;
  logic [TCW-1:0] r_trn_cnt, w_trn_cnt_nxt;
  logic [FCW-1:0] r_frm_cnt, w_frm_cnt_nxt;
  logic           w_marker;
  logic           w_acc;
  logic [PW-1:0]  w_payload;
  logic [FW-1:0]  w_frame;
  logic           w_trn_frame;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge Ck or negedge Rs) begin
    if (!Rs) r_rs_sync <= '0;
    else     r_rs_sync <= {r_rs_sync[0], 1'b1};
  end
  assign w_rst_n = r_rs_sync[1];

  always_ff @(posedge Ck or negedge w_rst_n) begin
    if (!w_rst_n) r_rt_sync <= '0;
    else if (CE)  r_rt_sync <= {r_rt_sync[1:0], Re_Trn};
  end
  assign w_rt_pe = r_rt_sync[1] & ~r_rt_sync[2];

  always_ff @(posedge Ck or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_TRAIN;
      r_trn_cnt <= '0;
      r_frm_cnt <= '0;
    end else if (CE) begin
      r_state   <= w_state_nxt;
      r_trn_cnt <= w_trn_cnt_nxt;
      r_frm_cnt <= w_frm_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_trn_cnt_nxt = r_trn_cnt;
    w_frm_cnt_nxt = r_frm_cnt;
    if (w_rt_pe) begin
      w_state_nxt   = ST_TRAIN;
      w_trn_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_TRAIN: begin
          w_trn_cnt_nxt = r_trn_cnt + TCW'(1);
          if (r_trn_cnt == TCW'(TRN - 1)) begin
            w_state_nxt   = ST_RUN;
            w_frm_cnt_nxt = '0;
          end
        end
        default: w_frm_cnt_nxt = r_frm_cnt + FCW'(1);
      endcase
    end
  end

  assign w_marker = (r_state == ST_RUN) && (r_frm_cnt == FCW'(AMP - 1));
  assign Usr_Rdy  = (r_state == ST_RUN) && !w_marker && !w_rt_pe;
  assign w_acc    = Usr_Vld & Usr_Rdy & CE;

`ifdef SICI_PCS_TX_SCR_EN
  sici_pcs_scr #(
    .W (PW)
  ) u_scr (
    .clk   (Ck),
    .rst_n (w_rst_n),
    .en    (w_acc & ~Usr_Ctl),
    .din   (Usr_Dat),
    .dout  (w_payload)
  );
`else
  assign w_payload = Usr_Dat;
`endif

  // Control payloads bypass the scrambler; only data frames use w_payload.
  always_comb begin
    w_frame     = {SH_CTL, IDLE_PAT};
    w_trn_frame = 1'b0;
    if (r_state == ST_TRAIN) begin
      w_frame     = {SH_CTL, TRN_PAT};
      w_trn_frame = 1'b1;
    end else if (w_marker) begin
      w_frame = {SH_CTL, AM_PAT};
    end else if (w_acc) begin
      w_frame = Usr_Ctl ? {SH_CTL, Usr_Dat} : {SH_DAT, w_payload};
    end
  end

  always_ff @(posedge Ck or negedge w_rst_n) begin
    if (!w_rst_n) begin
      Phy_Dat <= {SH_CTL, IDLE_PAT};
      Trn_Act <= 1'b1;
      AM_Pls  <= 1'b0;
    end else if (CE) begin
      Phy_Dat <= w_frame;
      Trn_Act <= w_trn_frame;
      AM_Pls  <= w_marker;
    end
  end

endmodule
`default_nettype wire
